imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 192 +++++++++++++++++++
 tb/tb_imem_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a program image over a UART byte stream and writes it
//             into instruction memory, holding the processor in reset until a
//             complete, well-formed image has been stored.
//             Stream format: 16-bit little-endian word count N, followed by
//             N little-endian 32-bit instruction words.
//  Ports    : clk          - single clock, rising edge
//             rst_n        - synchronous active-low reset
//             start        - one-cycle pulse, begins a load session
//             rx_valid     - byte strobe from the UART receiver
//             rx_data      - received byte
//             wr_en        - one-cycle instruction-memory write strobe
//             wr_addr      - byte address of the write (word aligned)
//             wr_data      - instruction word to write
//             cpu_run      - releases the processor when high
//             busy/done/error - session status
//             words_loaded - words written in the current session
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_SIZE      = 256,
   parameter int TIMEOUT       = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     wr_en,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     cpu_run,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [15:0]              words_loaded
);

   // Timer holds 0..TIMEOUT-1; reaching TIMEOUT idle cycles is the trip point.
   localparam int                  c_TIMER_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_LOAD   = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [15:0]            r_len;
   logic [31:0]            r_word;
   logic [1:0]             r_idx;
   logic [c_TIMER_W-1:0]   r_timer;
   logic [15:0]            r_words;
   logic                   r_last;
   logic                   r_wr_en;
   logic [ADDRESS_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0]  r_wr_data;

   logic                   w_accept;
   logic                   w_timeout;
   logic                   w_start_ok;
   logic [15:0]            w_len_full;
   logic                   w_len_bad;

   // Length as it will be once the high byte currently on rx_data is taken.
   assign w_len_full = {rx_data, r_len[7:0]};
   assign w_len_bad  = (w_len_full == 16'd0) || ({16'd0, w_len_full} > 32'(MEM_SIZE));

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and status outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      error       = 1'b0;
      cpu_run     = 1'b0;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      w_start_ok  = 1'b0;

      unique case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            done       = (r_state == S_DONE);
            cpu_run    = (r_state == S_DONE);
            error      = (r_state == S_ERROR);
            w_start_ok = start;
            if (start) begin
               w_state_nxt = S_LEN_LO;
            end
         end
         S_LEN_LO, S_LEN_HI, S_LOAD: begin
            busy = 1'b1;
            // Once the final word is complete, further bytes are not part of
            // this image and the timer no longer matters.
            w_accept  = rx_valid && !r_last;
            w_timeout = !rx_valid && !r_last && (r_timer == c_TIMER_MAX);
            if (r_state == S_LOAD && r_last && r_wr_en) begin
               w_state_nxt = S_DONE;
            end else if (w_timeout) begin
               w_state_nxt = S_ERROR;
            end else if (w_accept && r_state == S_LEN_LO) begin
               w_state_nxt = S_LEN_HI;
            end else if (w_accept && r_state == S_LEN_HI) begin
               w_state_nxt = w_len_bad ? S_ERROR : S_LOAD;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: length capture, word assembly, write strobe, idle timer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_word    <= '0;
         r_idx     <= '0;
         r_timer   <= '0;
         r_words   <= '0;
         r_last    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= 1'b0;
         // words_loaded advances at the end of the strobe cycle so that
         // wr_addr == 4*words_loaded while wr_en is high.
         if (r_wr_en) begin
            r_words <= r_words + 16'd1;
         end

         if (w_start_ok) begin
            r_len   <= '0;
            r_word  <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_words <= '0;
            r_last  <= 1'b0;
         end else if (w_accept) begin
            r_timer <= '0;
            unique case (r_state)
               S_LEN_LO: r_len[7:0]  <= rx_data;
               S_LEN_HI: r_len[15:8] <= rx_data;
               S_LOAD: begin
                  r_word[{r_idx, 3'b000} +: 8] <= rx_data;
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= ADDRESS_WIDTH'({r_words, 2'b00});
                     r_wr_data <= DATA_WIDTH'({rx_data, r_word[23:0]});
                     r_last    <= (r_words == r_len - 16'd1);
                  end
               end
               default: ;
            endcase
         end else if (busy) begin
            r_timer <= r_timer + c_TIMER_W'(1);
         end
      end
   end

   assign wr_en        = r_wr_en;
   assign wr_addr      = r_wr_addr;
   assign wr_data      = r_wr_data;
   assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Directed self-checking bench for imem_loader (small MEM_SIZE
//             and TIMEOUT so boundaries are reachable quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int MS  = 8;
   localparam int TMO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          cpu_run;
   logic          busy;
   logic          done;
   logic          error;
   logic [15:0]   words_loaded;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW-1:0] mon_addr[$];
   logic [DW-1:0] mon_data[$];

   imem_loader #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid),
      .rx_data(rx_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_run(cpu_run), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Write-strobe log, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         mon_addr.push_back(wr_addr);
         mon_data.push_back(wr_data);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Called at a negedge; presents a byte for exactly one rising edge.
   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int base;
      @(negedge clk);
      tick(2);
      // ---- reset state
      chk("rst_wr_en",  wr_en, 0);
      chk("rst_addr",   wr_addr, 0);
      chk("rst_data",   wr_data, 0);
      chk("rst_status", {cpu_run, busy, done, error}, 4'b0000);
      chk("rst_words",  words_loaded, 0);
      rst_n = 1'b1;
      tick(1);

      // ---- bytes while idle are ignored
      send(8'h01); send(8'h00);
      chk("idle_ignore", {busy, mon_addr.size()}, 0);

      // ---- nominal two-word load
      pulse_start();
      chk("nom_busy", {busy, done, error, cpu_run}, 4'b1000);
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h05); send(8'h00); send(8'h00);
      chk("nom_w0_en",    wr_en, 1);
      chk("nom_w0_addr",  wr_addr, 32'h0);
      chk("nom_w0_data",  wr_data, 32'h0000_0513);
      chk("nom_w0_words", words_loaded, 0);
      send(8'h6F);
      chk("nom_w0_pulse", {wr_en, words_loaded}, {1'b0, 16'd1});
      send(8'h00); send(8'h00); send(8'h00);
      chk("nom_w1", {wr_en, wr_addr, wr_data}, {1'b1, 32'h4, 32'h0000_006F});
      tick(1);
      chk("nom_done", {done, cpu_run, busy, error}, 4'b1100);
      chk("nom_words", words_loaded, 2);
      chk("nom_cnt", mon_addr.size(), 2);
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      chk("done_ignore", {mon_addr.size(), done}, {32'd2, 1'b1});

      // ---- zero length
      pulse_start();
      chk("restart_clear", {words_loaded, done, busy}, {16'd0, 1'b0, 1'b1});
      send(8'h00); send(8'h00);
      chk("len0_err", {error, busy, done, cpu_run}, 4'b1000);
      tick(3);
      chk("len0_hold", {error, mon_addr.size()}, {1'b1, 32'd2});

      // ---- length MEM_SIZE+1
      pulse_start();
      send(8'h09); send(8'h00);
      chk("len9_err", {error, busy, cpu_run}, 3'b100);

      // ---- timeout mid-word
      pulse_start();
      send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
      tick(TMO - 1);
      chk("tmo_pre", {busy, error}, 2'b10);
      tick(1);
      chk("tmo_err", {error, busy, cpu_run, done}, 4'b1000);
      chk("tmo_nowr", mon_addr.size(), 2);

      // ---- byte arriving on the timeout cycle wins
      pulse_start();
      send(8'h01); send(8'h00);
      tick(TMO - 1);
      send(8'h11);
      send(8'h22); send(8'h33); send(8'h44);
      chk("race_wr", {wr_en, wr_addr, wr_data}, {1'b1, 32'h0, 32'h4433_2211});
      tick(1);
      chk("race_done", {done, cpu_run, error}, 3'b110);

      // ---- reset mid-load after 6 bytes
      pulse_start();
      base = mon_addr.size();
      send(8'h02); send(8'h00); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_out", {wr_en, wr_addr, wr_data, words_loaded},
          {1'b0, 32'h0, 32'h0, 16'h0});
      chk("mid_rst_st", {cpu_run, busy, done, error}, 4'b0000);
      rst_n = 1'b1;
      tick(3);
      chk("mid_rst_nowr", mon_addr.size(), base + 1);
      pulse_start();
      send(8'h01); send(8'h00);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      chk("fresh_wr", {wr_en, wr_addr, wr_data}, {1'b1, 32'h0, 32'hDEAD_BEEF});
      tick(1);
      chk("fresh_done", {done, words_loaded}, {1'b1, 16'd1});

      // ---- back-to-back full memory, start asserted mid-load
      pulse_start();
      base = mon_addr.size();
      send(8'h08); send(8'h00);
      for (int i = 0; i < 4 * MS; i++) begin
         start = (i == 13);
         send(8'(i));
      end
      start = 1'b0;
      chk("b2b_last_wr", {wr_en, wr_addr, wr_data}, {1'b1, 32'h1C, 32'h1F1E_1D1C});
      tick(1);
      chk("b2b_done", {done, cpu_run, words_loaded}, {1'b1, 1'b1, 16'd8});
      chk("b2b_cnt", mon_addr.size() - base, MS);
      chk("b2b_first", {mon_addr[base], mon_data[base]}, {32'h0, 32'h0302_0100});
      chk("b2b_mid", {mon_addr[base+3], mon_data[base+3]}, {32'hC, 32'h0F0E_0D0C});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
